cv32e40p_apu_arbiter: RTL and testbench

Shares one CVFPU (cv32e40p_fp_wrapper) between NUM_CORES CV32E40P APU master ports, for clustered configurations with FPU=1.
- Arbitrates requests round-robin and holds the selection stable until the FPU grants.
- Records the issuing core ID in an in-order tag FIFO and routes each FPU response back to that core.
- Drives the FPU clock-gate enable.

---
 rtl/cv32e40p_apu_core_pkg.sv | 34 +++
 rtl/cv32e40p_apu_arb_tag_fifo.sv | 63 ++++++
 rtl/cv32e40p_apu_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_apu_core_pkg.sv
// Purpose: APU width constants shared by the CV32E40P cores and the shared-FPU arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cv32e40p_apu_core_pkg;

    // APU interface widths as seen from the core side
    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

    // Shared-FPU arbiter support
    localparam int APU_ARB_MAX_CORES = 8;

    typedef logic [$clog2(APU_ARB_MAX_CORES)-1:0] apu_arb_id_t;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } apu_arb_state_t;

    // (base + off) mod n, valid for base < n and off <= n
    function automatic apu_arb_id_t apu_arb_wrap_add(input apu_arb_id_t base,
                                                     input int unsigned off,
                                                     input int unsigned n);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= n) begin
            s = s - n;
        end
        return apu_arb_id_t'(s);
    endfunction

endpackage

// File: rtl/cv32e40p_apu_arb_tag_fifo.sv
// Purpose: in-order FIFO of issuing core IDs for ops accepted by the shared FPU.
// Latency: push visible at dout one cycle later; dout is the combinational head.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keeps count.
//
// Ports: clk/rst (async active-high), push/din, pop/dout, full, empty, count.
module cv32e40p_apu_arb_tag_fifo
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  apu_arb_id_t   din,
    input  logic          pop,
    output apu_arb_id_t   dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    apu_arb_id_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Purpose: shares one CVFPU between NUM_CORES CV32E40P APU ports, round-robin, in-order response routing.
// Latency: request/grant path and response path are combinational (zero added cycles).
// Backpressure: selection is held until the FPU grants; no issue while MAX_OUTSTANDING tags are in flight.
//
// Ports: clk_i/rst_i (async active-high); core_* = per-core APU master side (flattened, core 0 in LSBs);
//        fpu_* = single FPU slave side; fpu_clk_en_o/busy_o = activity; err_o = sticky orphan response.
// Optional: define CV32E40P_APU_ARB_PERF_EN to add contention_cnt_o (saturating multi-request cycle count).
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int NARGS           = APU_NARGS_CPU,
    parameter int WOP             = APU_WOP_CPU,
    parameter int NDSFLAGS        = APU_NDSFLAGS_CPU,
    parameter int NUSFLAGS        = APU_NUSFLAGS_CPU
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_CORES-1:0]            core_req_i,
    output logic [NUM_CORES-1:0]            core_gnt_o,
    input  logic [NUM_CORES*NARGS*32-1:0]   core_operands_i,
    input  logic [NUM_CORES*WOP-1:0]        core_op_i,
    input  logic [NUM_CORES*NDSFLAGS-1:0]   core_flags_i,
    output logic [NUM_CORES-1:0]            core_rvalid_o,
    output logic [31:0]                     core_result_o,
    output logic [NUSFLAGS-1:0]             core_rflags_o,
    output logic                            fpu_req_o,
    input  logic                            fpu_gnt_i,
    output logic [NARGS*32-1:0]             fpu_operands_o,
    output logic [WOP-1:0]                  fpu_op_o,
    output logic [NDSFLAGS-1:0]             fpu_flags_o,
    input  logic                            fpu_rvalid_i,
    input  logic [31:0]                     fpu_rdata_i,
    input  logic [NUSFLAGS-1:0]             fpu_rflags_i,
    output logic                            fpu_clk_en_o,
    output logic                            busy_o,
    output logic                            err_o
`ifdef CV32E40P_APU_ARB_PERF_EN
    ,
    output logic [31:0]                     contention_cnt_o
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    // Requests and data padded to the maximum core count so a 3-bit ID indexes them directly
    logic [APU_ARB_MAX_CORES-1:0] req_pad;
    logic [NARGS*32-1:0]          ops_arr   [APU_ARB_MAX_CORES];
    logic [WOP-1:0]               op_arr    [APU_ARB_MAX_CORES];
    logic [NDSFLAGS-1:0]          flags_arr [APU_ARB_MAX_CORES];

    apu_arb_state_t state, state_nxt;
    apu_arb_id_t    rr_ptr, rr_ptr_nxt;
    apu_arb_id_t    locked_id, locked_id_nxt;
    apu_arb_id_t    scan_sel;
    apu_arb_id_t    winner;
    apu_arb_id_t    head;

    logic           any_req;
    logic           accept;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           err_q;

    assign req_pad = APU_ARB_MAX_CORES'(core_req_i);
    assign any_req = |core_req_i;

    always_comb begin
        for (int i = 0; i < APU_ARB_MAX_CORES; i++) begin
            ops_arr[i]   = '0;
            op_arr[i]    = '0;
            flags_arr[i] = '0;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            ops_arr[i]   = core_operands_i[i*NARGS*32 +: NARGS*32];
            op_arr[i]    = core_op_i[i*WOP +: WOP];
            flags_arr[i] = core_flags_i[i*NDSFLAGS +: NDSFLAGS];
        end
    end

    // Round-robin scan: walk from the farthest offset back to rr_ptr so the
    // nearest requester at or after rr_ptr is the last (winning) assignment.
    // With no requester the selection rests on core 0.
    always_comb begin
        scan_sel = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req_pad[apu_arb_wrap_add(rr_ptr, i, NUM_CORES)]) begin
                scan_sel = apu_arb_wrap_add(rr_ptr, i, NUM_CORES);
            end
        end
    end

    assign winner = (state == ARB_LOCKED) ? locked_id : scan_sel;

    // A locked core that withdrew its request leaves fpu_req_o low here
    assign fpu_req_o = req_pad[winner] & ~fifo_full & any_req;
    assign accept    = fpu_req_o & fpu_gnt_i;

    assign fpu_operands_o = ops_arr[winner];
    assign fpu_op_o       = op_arr[winner];
    assign fpu_flags_o    = flags_arr[winner];

    assign pop = fpu_rvalid_i & ~fifo_empty;

    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_gnt_o[i]    = accept & (winner == apu_arb_id_t'(i));
            core_rvalid_o[i] = pop & (head == apu_arb_id_t'(i));
        end
    end

    assign core_result_o = fpu_rdata_i;
    assign core_rflags_o = fpu_rflags_i;

    assign fpu_clk_en_o = any_req | (fifo_count != '0);
    assign busy_o       = fpu_clk_en_o;
    assign err_o        = err_q;

    // Lock / round-robin next state
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        locked_id_nxt = locked_id;
        if (accept) begin
            state_nxt  = ARB_FREE;
            rr_ptr_nxt = apu_arb_wrap_add(winner, 1, NUM_CORES);
        end else if (fpu_req_o) begin
            state_nxt     = ARB_LOCKED;
            locked_id_nxt = winner;
        end else if ((state == ARB_LOCKED) && !req_pad[locked_id]) begin
            state_nxt = ARB_FREE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ARB_FREE;
            rr_ptr    <= '0;
            locked_id <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            locked_id <= locked_id_nxt;
            // A response with no recorded issuer cannot be routed anywhere
            if (fpu_rvalid_i & fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    cv32e40p_apu_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (accept),
        .din   (winner),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef CV32E40P_APU_ARB_PERF_EN
    logic [31:0] contention_cnt;
    logic        multi_req;

    // x & (x-1) is non-zero exactly when two or more bits are set
    assign multi_req = |(core_req_i & (core_req_i - NUM_CORES'(1)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            contention_cnt <= '0;
        end else if (multi_req && (contention_cnt != '1)) begin
            contention_cnt <= contention_cnt + 32'd1;
        end
    end

    assign contention_cnt_o = contention_cnt;
`else
    // Contention counter not built in this configuration
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
module tb_cv32e40p_apu_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 4;
    localparam int NA   = 3;
    localparam int WOP  = 6;
    localparam int NDS  = 15;
    localparam int NUS  = 5;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [N-1:0]          core_req_i;
    logic [N-1:0]          core_gnt_o;
    logic [N*NA*32-1:0]    core_operands_i;
    logic [N*WOP-1:0]      core_op_i;
    logic [N*NDS-1:0]      core_flags_i;
    logic [N-1:0]          core_rvalid_o;
    logic [31:0]           core_result_o;
    logic [NUS-1:0]        core_rflags_o;
    logic                  fpu_req_o;
    logic                  fpu_gnt_i;
    logic [NA*32-1:0]      fpu_operands_o;
    logic [WOP-1:0]        fpu_op_o;
    logic [NDS-1:0]        fpu_flags_o;
    logic                  fpu_rvalid_i;
    logic [31:0]           fpu_rdata_i;
    logic [NUS-1:0]        fpu_rflags_i;
    logic                  fpu_clk_en_o;
    logic                  busy_o;
    logic                  err_o;
`ifdef CV32E40P_APU_ARB_PERF_EN
    logic [31:0]           contention_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    cv32e40p_apu_arbiter #(
        .NUM_CORES       (N),
        .MAX_OUTSTANDING (MAXO),
        .NARGS           (NA),
        .WOP             (WOP),
        .NDSFLAGS        (NDS),
        .NUSFLAGS        (NUS)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .core_req_i       (core_req_i),
        .core_gnt_o       (core_gnt_o),
        .core_operands_i  (core_operands_i),
        .core_op_i        (core_op_i),
        .core_flags_i     (core_flags_i),
        .core_rvalid_o    (core_rvalid_o),
        .core_result_o    (core_result_o),
        .core_rflags_o    (core_rflags_o),
        .fpu_req_o        (fpu_req_o),
        .fpu_gnt_i        (fpu_gnt_i),
        .fpu_operands_o   (fpu_operands_o),
        .fpu_op_o         (fpu_op_o),
        .fpu_flags_o      (fpu_flags_o),
        .fpu_rvalid_i     (fpu_rvalid_i),
        .fpu_rdata_i      (fpu_rdata_i),
        .fpu_rflags_i     (fpu_rflags_i),
        .fpu_clk_en_o     (fpu_clk_en_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
`ifdef CV32E40P_APU_ARB_PERF_EN
        ,
        .contention_cnt_o (contention_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: arbitration pointer, pending lock, queue of issuers
    int      m_rr;
    bit      m_lock;
    int      m_lid;
    int      m_q[$];
    bit      m_err;
    longint  m_perf;

    // Per-cycle decisions of the model, reused at the clock edge
    int      e_w;
    bit      e_req;
    bit      e_acc;
    bit      e_pop;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_lock = 0;
        m_lid  = 0;
        m_q.delete();
        m_err  = 0;
        m_perf = 0;
    endtask

    task automatic model_check();
        int nreq;
        e_w = 0;
        if (m_lock) begin
            e_w = m_lid;
        end else begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_rr + i) % N;
                if (core_req_i[c]) begin
                    e_w = c;
                    break;
                end
            end
        end
        e_req = core_req_i[e_w] && (m_q.size() < MAXO);
        e_acc = e_req && fpu_gnt_i;
        e_pop = fpu_rvalid_i && (m_q.size() > 0);
        nreq  = $countones(core_req_i);

        chk("fpu_req", fpu_req_o, e_req);
        chk("core_gnt", core_gnt_o, e_acc ? (1 << e_w) : 0);
        chk("fpu_operands", fpu_operands_o, core_operands_i[e_w*NA*32 +: NA*32]);
        chk("fpu_op", fpu_op_o, core_op_i[e_w*WOP +: WOP]);
        chk("fpu_flags", fpu_flags_o, core_flags_i[e_w*NDS +: NDS]);
        chk("core_rvalid", core_rvalid_o, e_pop ? (1 << m_q[0]) : 0);
        chk("core_result", core_result_o, fpu_rdata_i);
        chk("core_rflags", core_rflags_o, fpu_rflags_i);
        chk("fpu_clk_en", fpu_clk_en_o, (nreq > 0) || (m_q.size() > 0));
        chk("busy", busy_o, (nreq > 0) || (m_q.size() > 0));
        chk("err", err_o, m_err);
`ifdef CV32E40P_APU_ARB_PERF_EN
        chk("contention_cnt", contention_cnt_o, m_perf);
`endif
    endtask

    task automatic model_update();
        if (rst_i) begin
            model_reset();
        end else begin
            if (fpu_rvalid_i && (m_q.size() == 0)) m_err = 1;
            if (e_pop) void'(m_q.pop_front());
            if (e_acc) begin
                m_q.push_back(e_w);
                m_rr   = (e_w + 1) % N;
                m_lock = 0;
            end else if (e_req) begin
                m_lock = 1;
                m_lid  = e_w;
            end else if (m_lock && !core_req_i[m_lid]) begin
                m_lock = 0;
            end
            if (($countones(core_req_i) >= 2) && (m_perf != 64'hFFFF_FFFF)) m_perf++;
        end
    endtask

    // Inputs are changed 1 time unit after posedge; outputs are sampled 3 units after
    task automatic settle();
        #2;
        model_check();
    endtask

    task automatic adv();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic rand_data();
        for (int i = 0; i < N*NA; i++) core_operands_i[i*32 +: 32] = $urandom;
        core_op_i    = (N*WOP)'($urandom);
        core_flags_i = (N*NDS)'({$urandom, $urandom});
        fpu_rdata_i  = $urandom;
        fpu_rflags_i = NUS'($urandom);
    endtask

    task automatic do_reset();
        core_req_i   = '0;
        fpu_gnt_i    = 1'b0;
        fpu_rvalid_i = 1'b0;
        rst_i        = 1'b1;
        model_reset();
        settle();
        chk("rst_fpu_req", fpu_req_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_fpu_op_core0", fpu_op_o, core_op_i[WOP-1:0]);
        adv();
        rst_i = 1'b0;
    endtask

    int order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_i        = 1'b1;
        core_req_i   = '0;
        fpu_gnt_i    = 1'b0;
        fpu_rvalid_i = 1'b0;
        rand_data();
        #1;

        // Single core 2, result 3 cycles after the request
        do_reset();
        core_req_i = 4'b0100; fpu_gnt_i = 1'b1;
        settle();
        chk("t1_gnt", core_gnt_o, 4'b0100);
        chk("t1_fpu_op", fpu_op_o, core_op_i[2*WOP +: WOP]);
        adv();
        core_req_i = '0; fpu_gnt_i = 1'b0;
        step(); step();
        fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'h3F80_0000;
        settle();
        chk("t1_rvalid", core_rvalid_o, 4'b0100);
        chk("t1_result", core_result_o, 32'h3F80_0000);
        chk("t1_busy_rv", busy_o, 1'b1);
        adv();
        fpu_rvalid_i = 1'b0;
        settle();
        chk("t1_busy_after", busy_o, 1'b0);
        adv();

        // Fairness: all cores request, FPU always grants, one result per cycle
        do_reset();
        core_req_i = 4'b1111; fpu_gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fpu_rvalid_i = (k > 0);
            settle();
            chk("t2_gnt_order", core_gnt_o, 1 << order[k]);
            adv();
        end
        core_req_i = '0; fpu_rvalid_i = 1'b1;
        settle();
`ifdef CV32E40P_APU_ARB_PERF_EN
        chk("t2_contention", contention_cnt_o, 32'd6);
`endif
        adv();
        fpu_rvalid_i = 1'b0;
        step();

        // Backpressure: cores 1 and 3, FPU stalls for 5 cycles
        do_reset();
        for (int i = 0; i < N; i++) core_op_i[i*WOP +: WOP] = WOP'(10 + i);
        core_req_i = 4'b1010; fpu_gnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t3_held_op", fpu_op_o, 6'd11);
            chk("t3_no_gnt", core_gnt_o, 4'b0000);
            adv();
        end
        fpu_gnt_i = 1'b1;
        settle();
        chk("t3_gnt_core1", core_gnt_o, 4'b0010);
        adv();
        settle();
        chk("t3_gnt_core3", core_gnt_o, 4'b1000);
        adv();
        core_req_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b1;
        step(); step();
        fpu_rvalid_i = 1'b0;
        step();

        // Full FIFO: four accepts, then a pop does not allow a same-cycle issue
        do_reset();
        core_req_i = 4'b0001; fpu_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) step();
        settle();
        chk("t4_req_full", fpu_req_o, 1'b0);
        chk("t4_gnt_full", core_gnt_o, 4'b0000);
        adv();
        fpu_rvalid_i = 1'b1;
        settle();
        chk("t4_rvalid", core_rvalid_o, 4'b0001);
        chk("t4_req_popcycle", fpu_req_o, 1'b0);
        adv();
        fpu_rvalid_i = 1'b0;
        settle();
        chk("t4_regrant", core_gnt_o, 4'b0001);
        adv();
        core_req_i = '0; fpu_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) step();
        fpu_rvalid_i = 1'b0;
        step();

        // In-order routing with a simultaneous push and pop
        do_reset();
        fpu_gnt_i = 1'b1;
        core_req_i = 4'b1000; step();
        core_req_i = 4'b0001; step();
        core_req_i = 4'b0100; fpu_rvalid_i = 1'b1;
        settle();
        chk("t5_rv_core3", core_rvalid_o, 4'b1000);
        chk("t5_gnt_core2", core_gnt_o, 4'b0100);
        adv();
        core_req_i = '0;
        settle();
        chk("t5_rv_core0", core_rvalid_o, 4'b0001);
        chk("t5_busy", busy_o, 1'b1);
        adv();
        settle();
        chk("t5_rv_core2", core_rvalid_o, 4'b0100);
        adv();
        fpu_rvalid_i = 1'b0; fpu_gnt_i = 1'b0;
        settle();
        chk("t5_busy_end", busy_o, 1'b0);
        adv();

        // Spurious response after reset
        do_reset();
        fpu_rvalid_i = 1'b1;
        settle();
        chk("t6_no_rvalid", core_rvalid_o, 4'b0000);
        chk("t6_err_before", err_o, 1'b0);
        adv();
        fpu_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t6_err_sticky", err_o, 1'b1);
            adv();
        end

        // Reset with ops in flight discards their tags
        do_reset();
        core_req_i = 4'b0001; fpu_gnt_i = 1'b1;
        step(); step();
        do_reset();
        fpu_rvalid_i = 1'b1;
        settle();
        chk("t7_no_rvalid", core_rvalid_o, 4'b0000);
        adv();
        fpu_rvalid_i = 1'b0;
        settle();
        chk("t7_err", err_o, 1'b1);
        adv();

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            int rv_pct;
            rv_pct = ((k / 500) % 2 == 0) ? 25 : 70;
            rand_data();
            if ($urandom_range(0, 3) == 0) core_req_i = N'($urandom) & N'($urandom);
            else                           core_req_i = N'($urandom);
            fpu_gnt_i    = ($urandom_range(0, 3) != 0);
            fpu_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 99) < rv_pct);
            if ($urandom_range(0, 1499) == 0) fpu_rvalid_i = 1'b1;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
